// File: rtl/dmem_imem_port_arbiter.sv
// dmem_imem_port_arbiter
// Shares one single-port unified memory between the IF stage (instruction
// fetch) and the MEM stage (load/store). Accesses run one at a time over a
// level request / one-cycle ack handshake. A combinational global stall holds
// the pipeline until every access needed this cycle has completed. Sticky
// done flags keep finished results from being fetched a second time while
// the pipeline is frozen.

module dmem_imem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] if_rdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              stall,
    output logic              err_timeout,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic              ram_ack,
    input  logic [DATA_W-1:0] ram_rdata
);

    // The counter is wide enough to hold TIMEOUT, and never narrower than 4 bits
    localparam int TCNT_RAW = $clog2(TIMEOUT + 1);
    localparam int TCNT_W   = (TCNT_RAW < 4) ? 4 : TCNT_RAW;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        INST = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              d_done;
    logic              i_done;
    logic [TCNT_W-1:0] tcnt;

    logic dreq;
    logic d_pend;
    logic i_pend;
    logic busy;
    logic timed_out;
    logic finish;

    // A load and a store in the same cycle is treated as a store
    assign dreq   = mem_read | mem_write;
    assign d_pend = dreq & ~d_done;
    assign i_pend = if_req & ~i_done;
    assign stall  = d_pend | i_pend;

    assign busy      = (state != IDLE);
    assign ram_req   = busy;
    assign timed_out = busy & ~ram_ack & (tcnt == TCNT_LAST);
    assign finish    = busy & (ram_ack | timed_out);

    // Next-state decision: data beats fetch because it belongs to the older instruction
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (d_pend) begin
                    state_nxt = DATA;
                end else if (i_pend) begin
                    state_nxt = INST;
                end
            end
            DATA, INST: begin
                if (finish) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the request fields at issue so they stay stable for the whole access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else if (state == IDLE) begin
            if (d_pend) begin
                ram_we    <= mem_write;
                ram_addr  <= mem_addr;
                ram_wdata <= mem_wdata;
            end else if (i_pend) begin
                ram_we   <= 1'b0;
                ram_addr <= if_addr;
            end
        end
    end

    // Cycles spent waiting for an ack in the current access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
        end else if (busy & ~finish) begin
            tcnt <= tcnt + TCNT_W'(1);
        end else begin
            tcnt <= '0;
        end
    end

    // Return data; an abandoned access yields zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dm_rdata <= '0;
            if_rdata <= '0;
        end else if (finish) begin
            if (state == DATA) begin
                if (timed_out) begin
                    dm_rdata <= '0;
                end else if (!ram_we) begin
                    dm_rdata <= ram_rdata;
                end
            end else if (state == INST) begin
                if_rdata <= timed_out ? '0 : ram_rdata;
            end
        end
    end

    // Done flags hold results until the pipeline advances, then clear together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_done <= 1'b0;
            i_done <= 1'b0;
        end else if (!stall) begin
            d_done <= 1'b0;
            i_done <= 1'b0;
        end else begin
            if (finish && state == DATA) begin
                d_done <= 1'b1;
            end
            if (finish && state == INST) begin
                i_done <= 1'b1;
            end
        end
    end

    // Sticky timeout indication, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_timeout <= 1'b0;
        end else if (timed_out) begin
            err_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_imem_port_arbiter.sv
// Bench for dmem_imem_port_arbiter: a behavioural memory answers requests
// with a programmable ack delay and logs every issued access; expected
// accesses are queued as each pipeline step is driven and matched once the
// stall releases. A vector table covers the steady-state cases, hand-written
// sequences cover reset, timeout and reset in the middle of an access.
`timescale 1ns/1ps

module tb_dmem_imem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic              clk;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] if_rdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              stall;
    logic              err_timeout;
    logic              ram_req;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_ack;
    logic [DATA_W-1:0] ram_rdata;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        string       name;
        logic        if_req;
        logic [31:0] if_addr;
        logic        mem_read;
        logic        mem_write;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        int          ack_delay;
        int          exp_stall;
        logic [31:0] exp_if;
        logic [31:0] exp_dm;
        logic        exp_err;
    } vec_t;

    acc_t exp_q[$];
    acc_t obs_q[$];
    logic [31:0] mem [logic [31:0]];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          stab_err = 0;
    int          ack_delay = 0;
    logic        noack_en = 1'b0;
    logic [31:0] noack_addr = 32'h0;
    logic        force_mode = 1'b0;
    logic        force_ack = 1'b0;
    logic [31:0] force_data = 32'h0;

    vec_t vecs[10];

    dmem_imem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .if_rdata   (if_rdata),
        .dm_rdata   (dm_rdata),
        .stall      (stall),
        .err_timeout(err_timeout),
        .ram_req    (ram_req),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_ack    (ram_ack),
        .ram_rdata  (ram_rdata)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something never settles
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Behavioural memory: logs each new request, checks field stability, answers with an ack
    initial begin : mem_model
        acc_t held;
        int   req_cycles;
        logic prev_req;
        mem[32'h0000_0040] = 32'h8C22_0004;
        mem[32'h0000_0044] = 32'h0000_0020;
        mem[32'h0000_0048] = 32'h1111_1111;
        mem[32'h0000_004C] = 32'h2222_2222;
        mem[32'h0000_0050] = 32'h3333_3333;
        mem[32'h0000_0100] = 32'hDEAD_BEEF;
        ram_ack    = 1'b0;
        ram_rdata  = 32'hFFFF_FFFF;
        req_cycles = 0;
        prev_req   = 1'b0;
        held       = '{we: 1'b0, addr: 32'h0, wdata: 32'h0};
        forever begin
            @(posedge clk);
            #1;
            if (ram_req === 1'b1) begin
                if (!prev_req) begin
                    held = '{we: ram_we, addr: ram_addr, wdata: ram_wdata};
                    obs_q.push_back(held);
                    req_cycles = 0;
                end else begin
                    req_cycles++;
                    if (ram_we !== held.we || ram_addr !== held.addr ||
                        (held.we && ram_wdata !== held.wdata)) begin
                        stab_err++;
                    end
                end
            end
            prev_req = (ram_req === 1'b1);
            if (force_mode) begin
                ram_ack   = force_ack;
                ram_rdata = force_data;
            end else if (ram_req === 1'b1 && !(noack_en && ram_addr == noack_addr) &&
                         req_cycles == ack_delay) begin
                ram_ack = 1'b1;
                if (ram_we) begin
                    mem[ram_addr] = ram_wdata;
                    ram_rdata     = 32'hFFFF_FFFF;
                end else begin
                    ram_rdata = mem.exists(ram_addr) ? mem[ram_addr] : 32'h0;
                end
            end else begin
                ram_ack   = 1'b0;
                ram_rdata = 32'hFFFF_FFFF;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one pipeline step just after the edge and queue its expected accesses, data first
    task automatic apply_stimulus(input vec_t v);
        @(posedge clk);
        #2;
        if_req    = v.if_req;
        if_addr   = v.if_addr;
        mem_read  = v.mem_read;
        mem_write = v.mem_write;
        mem_addr  = v.mem_addr;
        mem_wdata = v.mem_wdata;
        ack_delay = v.ack_delay;
        if (v.mem_read | v.mem_write) begin
            exp_q.push_back('{we: v.mem_write, addr: v.mem_addr, wdata: v.mem_wdata});
        end
        if (v.if_req) begin
            exp_q.push_back('{we: 1'b0, addr: v.if_addr, wdata: 32'h0});
        end
    endtask

    // Count stalled cycles until the pipeline is released, bounded
    task automatic wait_release(input string name, output int cycles);
        cycles = 0;
        @(negedge clk);
        while (stall === 1'b1 && cycles < 64) begin
            cycles++;
            @(negedge clk);
        end
        if (stall !== 1'b0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s_release: stall still 0x%0h after %0d cycles, expected 0", name, stall, cycles);
        end
    endtask

    // Match logged accesses against the expected ones, in order, with nothing extra
    task automatic compare_accesses(input string name);
        acc_t e;
        acc_t o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL %s_access: got no request, expected addr 0x%08h", name, e.addr);
            end else begin
                o = obs_q.pop_front();
                check({name, "_we"}, 32'(o.we), 32'(e.we));
                check({name, "_addr"}, o.addr, e.addr);
                if (e.we) begin
                    check({name, "_wdata"}, o.wdata, e.wdata);
                end
            end
        end
        check({name, "_extra_requests"}, 32'(obs_q.size()), 32'd0);
        obs_q.delete();
    endtask

    task automatic check_output(input vec_t v, input int cycles);
        check({v.name, "_stall_cycles"}, 32'(cycles), 32'(v.exp_stall));
        check({v.name, "_if_rdata"}, if_rdata, v.exp_if);
        check({v.name, "_dm_rdata"}, dm_rdata, v.exp_dm);
        check({v.name, "_err_timeout"}, 32'(err_timeout), 32'(v.exp_err));
        compare_accesses(v.name);
    endtask

    initial begin : main
        int   cycles;
        vec_t v;

        vecs[0] = '{"fetch_only",   1'b1, 32'h40, 1'b0, 1'b0, 32'h000, 32'h0,          1, 3, 32'h8C22_0004, 32'h0000_0000, 1'b0};
        vecs[1] = '{"load_fetch",   1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0,          0, 4, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{"store_fetch",  1'b1, 32'h48, 1'b0, 1'b1, 32'h200, 32'h1234_5678,  2, 8, 32'h1111_1111, 32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{"load_back",    1'b0, 32'h00, 1'b1, 1'b0, 32'h200, 32'h0,          1, 3, 32'h1111_1111, 32'h1234_5678, 1'b0};
        vecs[4] = '{"b2b_load",     1'b1, 32'h4C, 1'b1, 1'b0, 32'h100, 32'h0,          1, 6, 32'h2222_2222, 32'hDEAD_BEEF, 1'b0};
        vecs[5] = '{"b2b_store",    1'b1, 32'h50, 1'b0, 1'b1, 32'h104, 32'hCAFE_F00D,  0, 4, 32'h3333_3333, 32'hDEAD_BEEF, 1'b0};
        vecs[6] = '{"rd_and_wr",    1'b0, 32'h00, 1'b1, 1'b1, 32'h300, 32'hA5A5_A5A5,  0, 2, 32'h3333_3333, 32'hDEAD_BEEF, 1'b0};
        vecs[7] = '{"no_request",   1'b0, 32'h00, 1'b0, 1'b0, 32'h000, 32'h0,          0, 0, 32'h3333_3333, 32'hDEAD_BEEF, 1'b0};
        vecs[8] = '{"load_stored",  1'b0, 32'h00, 1'b1, 1'b0, 32'h104, 32'h0,          3, 5, 32'h3333_3333, 32'hCAFE_F00D, 1'b0};
        vecs[9] = '{"load_rdwr",    1'b0, 32'h00, 1'b1, 1'b0, 32'h300, 32'h0,          0, 2, 32'h3333_3333, 32'hA5A5_A5A5, 1'b0};

        // Reset state, with a fetch already requested so stall shows through
        rst       = 1'b1;
        if_req    = 1'b1;
        if_addr   = 32'h40;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        repeat (2) @(negedge clk);
        check("reset_ram_req", 32'(ram_req), 32'd0);
        check("reset_ram_addr", ram_addr, 32'h0);
        check("reset_if_rdata", if_rdata, 32'h0);
        check("reset_dm_rdata", dm_rdata, 32'h0);
        check("reset_err", 32'(err_timeout), 32'd0);
        check("reset_stall", 32'(stall), 32'd1);
        @(posedge clk);
        #2;
        if_req = 1'b0;
        rst    = 1'b0;

        // Steady-state vectors
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i]);
            wait_release(vecs[i].name, cycles);
            check_output(vecs[i], cycles);
        end

        // Load that is never acked: abandoned after TIMEOUT cycles, then the fetch proceeds
        noack_en   = 1'b1;
        noack_addr = 32'h400;
        v = '{"timeout", 1'b1, 32'h44, 1'b1, 1'b0, 32'h400, 32'h0, 0, 18, 32'h0000_0020, 32'h0, 1'b1};
        apply_stimulus(v);
        wait_release(v.name, cycles);
        check_output(v, cycles);

        // Timeout flag stays set across a later normal access
        v = '{"after_timeout", 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 0, 2, 32'h8C22_0004, 32'h0, 1'b1};
        apply_stimulus(v);
        wait_release(v.name, cycles);
        check_output(v, cycles);

        // Reset two cycles into a load, then a late ack that must be ignored
        noack_addr = 32'h100;
        v = '{"rst_mid", 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 0, 0, 32'h0, 32'h0, 1'b0};
        apply_stimulus(v);
        exp_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
        @(posedge clk);
        @(posedge clk);
        #2;
        force_data = 32'hBAD0_BAD0;
        force_ack  = 1'b1;
        force_mode = 1'b1;
        rst        = 1'b1;
        @(negedge clk);
        check("rst_mid_ram_req", 32'(ram_req), 32'd0);
        check("rst_mid_ram_we", 32'(ram_we), 32'd0);
        check("rst_mid_ram_addr", ram_addr, 32'h0);
        check("rst_mid_ram_wdata", ram_wdata, 32'h0);
        check("rst_mid_if_rdata", if_rdata, 32'h0);
        check("rst_mid_err", 32'(err_timeout), 32'd0);
        check("rst_mid_stall", 32'(stall), 32'd1);
        @(posedge clk);
        #2;
        rst        = 1'b0;
        force_mode = 1'b0;
        noack_en   = 1'b0;
        ack_delay  = 0;
        @(negedge clk);
        check("rst_mid_late_ack_req", 32'(ram_req), 32'd0);
        @(negedge clk);
        check("rst_mid_reissue_req", 32'(ram_req), 32'd1);
        check("rst_mid_reissue_addr", ram_addr, 32'h100);
        check("rst_mid_ignored_ack", dm_rdata, 32'h0);
        wait_release("rst_mid", cycles);
        check("rst_mid_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
        compare_accesses("rst_mid");

        // Quiet pipeline: nothing further may be issued
        @(posedge clk);
        #2;
        mem_read = 1'b0;
        if_req   = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_no_request", 32'(obs_q.size()), 32'd0);
        check("request_fields_stable", 32'(stab_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
